// File: rtl/instr_mem_ctrl.sv
// Clocked instruction memory: req/gnt fetch port, READ_LATENCY-deep in-order response pipe, byte-enabled load port.
// Response READ_LATENCY cycles after grant; no response backpressure, fetches stalled (gnt=0) while a load is written.
module instr_mem_ctrl #(
  parameter int unsigned          ADDR_WIDTH   = 32,
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter int unsigned          DEPTH_WORDS  = 8192,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned          READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_wdata_i,
  input  logic [3:0]            load_be_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];
  logic                    ready_q;
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  // Extra top bit is the borrow: addresses below BASE_ADDR land above SPAN.
  logic [ADDR_WIDTH:0]  fetch_off, load_off;
  logic                 fetch_ok, load_in;
  logic [IDX_W-1:0]     fetch_idx, load_idx;
  logic                 vld_d, err_d;
  logic [DATA_WIDTH-1:0] dat_d;

  assign fetch_off = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
  assign load_off  = {1'b0, load_addr_i}  - {1'b0, BASE_ADDR};
  assign fetch_ok  = (fetch_off < SPAN) && (fetch_off[1:0] == 2'b00);
  assign load_in   = (load_off < SPAN);
  assign fetch_idx = fetch_off[IDX_W+1:2];
  assign load_idx  = load_off[IDX_W+1:2];

  assign instr_gnt_o = instr_req_i & ready_q & ~load_we_i;

  always_comb begin
    vld_d = instr_req_i & instr_gnt_o;
    err_d = ~fetch_ok;
    dat_d = '0;
    if (fetch_ok) dat_d = mem_q[fetch_idx];
  end

  // Data/err only advance behind a valid entry so the last stage holds the previous response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      vld_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) dat_q[i] <= '0;
    end else begin
      ready_q  <= 1'b1;
      vld_q[0] <= vld_d;
      if (vld_d) begin
        err_q[0] <= err_d;
        dat_q[0] <= dat_d;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          err_q[i] <= err_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i && load_in) begin
      for (int b = 0; b < 4; b++) begin
        if (load_be_i[b]) mem_q[load_idx][8*b +: 8] <= load_wdata_i[8*b +: 8];
      end
    end
  end

  assign instr_rvalid_o = vld_q[READ_LATENCY-1];
  assign instr_err_o    = err_q[READ_LATENCY-1];
  assign instr_rdata_o  = dat_q[READ_LATENCY-1];

endmodule
